// File: rtl/adc_scan_ctrl.sv
// ADC input-channel scan controller: byte-wide register file plus a sequencing FSM
// that steps SEL through the enabled channels and triggers one or more conversions on each.
//
// state   | meaning
// IDLE    | no scan running; SEL holds the last channel
// SELECT  | drive SEL from the channel pointer, clear per-channel count, load settle timer
// SETTLE  | count the settle timer down to zero
// TRIGGER | hold while the readout FIFO is near full, otherwise fire SEQ_START
// WAIT    | wait for SEQ_DONE and count the conversion
// NEXT    | move to the next enabled channel, wrap in continuous mode, or finish
module adc_scan_ctrl #(
   parameter logic [15:0] BASEADDR  = 16'h0000,
   parameter logic [15:0] HIGHADDR  = 16'h000f,
   parameter int          ABUSWIDTH = 16
) (
   input  logic                 BUS_CLK,
   input  logic                 BUS_RST,
   input  logic [ABUSWIDTH-1:0] BUS_ADD,
   inout  wire  [7:0]           BUS_DATA,
   input  logic                 BUS_RD,
   input  logic                 BUS_WR,
   output logic                 SEQ_START,
   input  logic                 SEQ_DONE,
   input  logic                 FIFO_NEAR_FULL,
   output logic [2:0]           SEL,
   output logic                 BUSY
);

   localparam logic [ABUSWIDTH-1:0] BASE = ABUSWIDTH'(BASEADDR);
   localparam logic [ABUSWIDTH-1:0] SPAN = ABUSWIDTH'(HIGHADDR) - BASE;
   localparam logic [7:0]           VERSION = 8'h01;

   typedef enum logic [2:0] {
      ST_IDLE, ST_SELECT, ST_SETTLE, ST_TRIGGER, ST_WAIT, ST_NEXT
   } state_t;

   state_t state, state_nxt;

   logic [ABUSWIDTH-1:0] off;
   logic                 hit;
   logic                 soft_rst, rst_all;
   logic                 wr_ctrl, wr_mask, wr_settle, wr_nconv;
   logic                 start_req, stop_req;

   logic       cont, done, err;
   logic [7:0] ch_mask, settle, nconv;
   logic [15:0] count;
   logic [7:0] conv_cnt, settle_cnt;
   logic [2:0] ptr, ptr_nxt, sel_q;
   logic       seq_start_q;

   logic       scan_begin, scan_err, scan_end, load_sel, settle_dec, trig_fire, conv_done;
   logic [7:0] above;
   logic [3:0] low_pick, high_pick;
   logic [7:0] nconv_eff;
   logic       last_conv;

   logic [7:0] rd_mux, rd_data;
   logic       rd_valid;

   // Offsets below BASE wrap to large values, so one compare covers both bounds.
   assign off = BUS_ADD - BASE;
   assign hit = (off <= SPAN);

   assign soft_rst  = BUS_WR && hit && (off == ABUSWIDTH'(0));
   assign wr_ctrl   = BUS_WR && hit && (off == ABUSWIDTH'(1));
   assign wr_mask   = BUS_WR && hit && (off == ABUSWIDTH'(2));
   assign wr_settle = BUS_WR && hit && (off == ABUSWIDTH'(3));
   assign wr_nconv  = BUS_WR && hit && (off == ABUSWIDTH'(4));
   assign rst_all   = BUS_RST || soft_rst;

   assign stop_req  = wr_ctrl && BUS_DATA[2];
   assign start_req = wr_ctrl && BUS_DATA[0] && !BUS_DATA[2];

   function automatic logic [3:0] first_set(input logic [7:0] m);
      logic [3:0] r;
      r = 4'h0;
      for (int i = 7; i >= 0; i--)
         if (m[i]) r = {1'b1, 3'(i)};
      return r;
   endfunction

   always_comb begin
      above = 8'h00;
      for (int i = 0; i < 8; i++)
         above[i] = ch_mask[i] && (i > int'(ptr));
   end

   assign low_pick  = first_set(ch_mask);
   assign high_pick = first_set(above);
   assign nconv_eff = (nconv == 8'd0) ? 8'd1 : nconv;
   assign last_conv = ({1'b0, conv_cnt} + 9'd1) >= {1'b0, nconv_eff};

   always_ff @(posedge BUS_CLK) begin
      if (rst_all) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      ptr_nxt    = ptr;
      scan_begin = 1'b0;
      scan_err   = 1'b0;
      scan_end   = 1'b0;
      load_sel   = 1'b0;
      settle_dec = 1'b0;
      trig_fire  = 1'b0;
      conv_done  = 1'b0;
      case (state)
         ST_IDLE:
            if (start_req) begin
               if (low_pick[3]) begin
                  scan_begin = 1'b1;
                  ptr_nxt    = low_pick[2:0];
                  state_nxt  = ST_SELECT;
               end else begin
                  scan_err = 1'b1;
               end
            end
         ST_SELECT: begin
            load_sel  = 1'b1;
            state_nxt = ST_SETTLE;
         end
         ST_SETTLE:
            if (settle_cnt == 8'd0) state_nxt = ST_TRIGGER;
            else                    settle_dec = 1'b1;
         ST_TRIGGER:
            if (!FIFO_NEAR_FULL) begin
               trig_fire = 1'b1;
               state_nxt = ST_WAIT;
            end
         ST_WAIT:
            if (SEQ_DONE) begin
               conv_done = 1'b1;
               state_nxt = last_conv ? ST_NEXT : ST_TRIGGER;
            end
         ST_NEXT:
            if (high_pick[3]) begin
               ptr_nxt   = high_pick[2:0];
               state_nxt = ST_SELECT;
            end else if (cont && low_pick[3]) begin
               ptr_nxt   = low_pick[2:0];
               state_nxt = ST_SELECT;
            end else begin
               scan_end  = 1'b1;
               state_nxt = ST_IDLE;
            end
         default: state_nxt = ST_IDLE;
      endcase
      // STOP aborts without touching DONE and without a last trigger.
      if (stop_req) begin
         state_nxt  = ST_IDLE;
         ptr_nxt    = ptr;
         scan_begin = 1'b0;
         scan_end   = 1'b0;
         load_sel   = 1'b0;
         settle_dec = 1'b0;
         trig_fire  = 1'b0;
         conv_done  = 1'b0;
      end
   end

   always_ff @(posedge BUS_CLK) begin
      if (rst_all) begin
         cont        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         ch_mask     <= 8'h00;
         settle      <= 8'h00;
         nconv       <= 8'h00;
         count       <= 16'h0000;
         ptr         <= 3'd0;
         sel_q       <= 3'd0;
         conv_cnt    <= 8'h00;
         settle_cnt  <= 8'h00;
         seq_start_q <= 1'b0;
      end else begin
         seq_start_q <= trig_fire;
         ptr         <= ptr_nxt;
         if (wr_ctrl)   cont    <= BUS_DATA[1];
         if (wr_mask)   ch_mask <= BUS_DATA;
         if (wr_settle) settle  <= BUS_DATA;
         if (wr_nconv)  nconv   <= BUS_DATA;
         if (scan_begin) begin
            done  <= 1'b0;
            err   <= 1'b0;
            count <= 16'h0000;
         end
         if (scan_err) err  <= 1'b1;
         if (scan_end) done <= 1'b1;
         if (load_sel) begin
            sel_q      <= ptr;
            conv_cnt   <= 8'h00;
            settle_cnt <= settle;
         end
         if (settle_dec) settle_cnt <= settle_cnt - 8'd1;
         if (conv_done) begin
            count    <= count + 16'd1;
            conv_cnt <= conv_cnt + 8'd1;
         end
      end
   end

   always_comb begin
      rd_mux = 8'h00;
      if (off < ABUSWIDTH'(8)) begin
         case (off[2:0])
            3'd0: rd_mux = VERSION;
            3'd1: rd_mux = {5'b0, err, cont, done};
            3'd2: rd_mux = ch_mask;
            3'd3: rd_mux = settle;
            3'd4: rd_mux = nconv;
            3'd5: rd_mux = {5'b0, sel_q};
            3'd6: rd_mux = count[7:0];
            3'd7: rd_mux = count[15:8];
            default: rd_mux = 8'h00;
         endcase
      end
   end

   always_ff @(posedge BUS_CLK) begin
      if (rst_all) begin
         rd_valid <= 1'b0;
         rd_data  <= 8'h00;
      end else begin
         rd_valid <= BUS_RD && hit;
         rd_data  <= rd_mux;
      end
   end

   assign BUS_DATA  = rd_valid ? rd_data : 8'hzz;
   assign SEQ_START = seq_start_q;
   assign SEL       = sel_q;
   assign BUSY      = (state != ST_IDLE);

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Directed bench for adc_scan_ctrl: register access, scan order, settle timing,
// back-pressure, STOP, count wrap and mid-scan reset.
module tb_adc_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] add = 16'h0000;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic [7:0]  tb_data = 8'h00;
   logic        tb_drive = 1'b0;
   wire  [7:0]  bus_data;
   logic        seq_start;
   logic        fifo = 1'b0;
   logic        manual_done = 1'b0;
   logic        auto_done;
   logic        auto_en = 1'b0;
   logic [2:0]  sel;
   logic        busy;
   wire         seq_done = auto_done | manual_done;

   int errors = 0;
   int checks = 0;
   int pulses = 0;
   logic [2:0] sel_log [256];

   assign bus_data = tb_drive ? tb_data : 8'hzz;

   adc_scan_ctrl dut (
      .BUS_CLK(clk), .BUS_RST(rst), .BUS_ADD(add), .BUS_DATA(bus_data),
      .BUS_RD(rd), .BUS_WR(wr), .SEQ_START(seq_start), .SEQ_DONE(seq_done),
      .FIFO_NEAR_FULL(fifo), .SEL(sel), .BUSY(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // pulse monitor: records SEL at every SEQ_START
   initial forever begin
      @(negedge clk);
      if (seq_start) begin
         sel_log[pulses[7:0]] = sel;
         pulses = pulses + 1;
      end
   end

   // sequencer model: SEQ_DONE five cycles after each pulse
   initial begin
      auto_done = 1'b0;
      forever begin
         @(negedge clk);
         if (seq_start && auto_en) begin
            repeat (5) @(posedge clk);
            #1 auto_done = 1'b1;
            @(posedge clk);
            #1 auto_done = 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr_reg(input logic [15:0] a, input logic [7:0] d);
      add = a; tb_data = d; tb_drive = 1'b1; wr = 1'b1;
      @(posedge clk);
      #1 wr = 1'b0; tb_drive = 1'b0;
   endtask

   task automatic rd_reg(input logic [15:0] a, output logic [7:0] d);
      add = a; rd = 1'b1;
      @(posedge clk);
      #1 rd = 1'b0;
      @(negedge clk);
      d = bus_data;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
      logic [7:0] d;
      rd_reg(a, d);
      chk(tag, {24'h0, d}, {24'h0, exp});
   endtask

   task automatic wait_idle(input string tag, input int max);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      chk(tag, {31'h0, ok}, 32'h1);
      @(posedge clk);
      #1;
   endtask

   task automatic meas_lat(output int lat);
      lat = 99;
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk);
         if (seq_start) begin
            lat = i;
            break;
         end
      end
   endtask

   initial begin
      int p0, p1, lat3, lat0;
      logic seen;

      tick(3);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_start", {31'h0, seq_start}, 32'h0);
      chk("rst_sel", {29'h0, sel}, 32'h0);
      @(posedge clk); #1;
      chk_rd("version", 16'h0000, 8'h01);
      chk_rd("rst_ctrl", 16'h0001, 8'h00);
      chk_rd("unmapped", 16'h0008, 8'h00);

      // two-channel scan, settle 3 then settle 0
      auto_en = 1'b1;
      wr_reg(16'h0002, 8'h05);
      wr_reg(16'h0003, 8'h03);
      wr_reg(16'h0004, 8'h02);
      chk_rd("mask_rb", 16'h0002, 8'h05);
      p0 = pulses;
      wr_reg(16'h0001, 8'h01);
      meas_lat(lat3);
      wait_idle("scan_a_end", 300);
      chk("scan_a_pulses", pulses - p0, 4);
      chk("scan_a_sel0", {29'h0, sel_log[(p0 + 0) & 255]}, 0);
      chk("scan_a_sel1", {29'h0, sel_log[(p0 + 1) & 255]}, 0);
      chk("scan_a_sel2", {29'h0, sel_log[(p0 + 2) & 255]}, 2);
      chk("scan_a_sel3", {29'h0, sel_log[(p0 + 3) & 255]}, 2);
      chk("scan_a_selhold", {29'h0, sel}, 2);
      chk_rd("scan_a_ctrl", 16'h0001, 8'h01);
      chk_rd("scan_a_cnt_lo", 16'h0006, 8'h04);
      chk_rd("scan_a_cnt_hi", 16'h0007, 8'h00);
      chk_rd("scan_a_chan", 16'h0005, 8'h02);
      wr_reg(16'h0003, 8'h00);
      p0 = pulses;
      wr_reg(16'h0001, 8'h01);
      meas_lat(lat0);
      wait_idle("scan_b_end", 300);
      chk("scan_b_pulses", pulses - p0, 4);
      chk("settle_delta", lat3 - lat0, 3);

      // soft reset, then START with an empty mask
      wr_reg(16'h0000, 8'h5a);
      chk_rd("soft_mask", 16'h0002, 8'h00);
      chk_rd("soft_ctrl", 16'h0001, 8'h00);
      chk_rd("soft_cnt", 16'h0006, 8'h00);
      p0 = pulses;
      wr_reg(16'h0001, 8'h01);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         seen = seen | busy;
      end
      @(posedge clk); #1;
      chk("empty_busy", {31'h0, seen}, 32'h0);
      chk("empty_pulses", pulses - p0, 0);
      chk_rd("empty_err", 16'h0001, 8'h04);

      // continuous single channel, then STOP
      wr_reg(16'h0002, 8'h80);
      wr_reg(16'h0004, 8'h01);
      p0 = pulses;
      wr_reg(16'h0001, 8'h03);
      tick(60);
      chk("cont_pulses", {31'h0, (pulses - p0) >= 3}, 32'h1);
      for (int k = p0; k < pulses; k++)
         chk("cont_sel", {29'h0, sel_log[k & 255]}, 7);
      chk("cont_busy", {31'h0, busy}, 32'h1);
      wr_reg(16'h0001, 8'h06);
      p1 = pulses;
      @(negedge clk);
      chk("stop_busy", {31'h0, busy}, 32'h0);
      tick(30);
      chk("stop_pulses", pulses - p1, 0);
      chk_rd("stop_ctrl", 16'h0001, 8'h02);

      // FIFO back-pressure in TRIGGER
      auto_en = 1'b0;
      wr_reg(16'h0002, 8'h01);
      wr_reg(16'h0001, 8'h00);
      fifo = 1'b1;
      p0 = pulses;
      wr_reg(16'h0001, 8'h01);
      tick(25);
      chk("bp_nopulse", pulses - p0, 0);
      chk("bp_busy", {31'h0, busy}, 32'h1);
      fifo = 1'b0;
      @(negedge clk);
      chk("bp_same_cycle", {31'h0, seq_start}, 32'h0);
      @(negedge clk);
      chk("bp_next_cycle", {31'h0, seq_start}, 32'h1);
      @(negedge clk);
      chk("bp_one_wide", {31'h0, seq_start}, 32'h0);
      @(posedge clk); #1;
      manual_done = 1'b1;
      tick(1);
      manual_done = 1'b0;
      wait_idle("bp_end", 20);
      chk_rd("bp_ctrl", 16'h0001, 8'h01);
      chk_rd("bp_cnt", 16'h0006, 8'h01);

      // count wrap from 16'hffff
      wr_reg(16'h0001, 8'h01);
      tick(6);
      chk("wrap_in_wait", {31'h0, busy}, 32'h1);
      force dut.count = 16'hffff;
      #1 release dut.count;
      chk_rd("wrap_pre_lo", 16'h0006, 8'hff);
      chk_rd("wrap_pre_hi", 16'h0007, 8'hff);
      manual_done = 1'b1;
      tick(1);
      manual_done = 1'b0;
      wait_idle("wrap_end", 20);
      chk_rd("wrap_lo", 16'h0006, 8'h00);
      chk_rd("wrap_hi", 16'h0007, 8'h00);

      // BUS_RST while waiting for a conversion
      wr_reg(16'h0002, 8'h0c);
      wr_reg(16'h0003, 8'h02);
      wr_reg(16'h0004, 8'h03);
      wr_reg(16'h0001, 8'h03);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (seq_start) begin
            seen = 1'b1;
            break;
         end
      end
      chk("rstw_reached", {31'h0, seen}, 32'h1);
      chk("rstw_sel_pre", {29'h0, sel}, 2);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rstw_busy", {31'h0, busy}, 32'h0);
      chk("rstw_start", {31'h0, seq_start}, 32'h0);
      chk("rstw_sel", {29'h0, sel}, 0);
      @(posedge clk); #1;
      p0 = pulses;
      manual_done = 1'b1;
      tick(1);
      manual_done = 1'b0;
      tick(3);
      chk("rstw_stray_busy", {31'h0, busy}, 32'h0);
      chk("rstw_stray_pulse", pulses - p0, 0);
      chk_rd("rstw_mask", 16'h0002, 8'h00);
      chk_rd("rstw_ctrl", 16'h0001, 8'h00);
      chk_rd("rstw_settle", 16'h0003, 8'h00);
      chk_rd("rstw_nconv", 16'h0004, 8'h00);
      chk_rd("rstw_cnt", 16'h0006, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
